mem_port_arbiter: RTL

- Shares one single-ported memory between instruction fetch (read-only) and the load/store stage (driven by the mem_re/mem_we control bits).
- One transaction is outstanding at a time. Requests are captured into registers, and each response is routed back to the requester that owns it.
- Data requests have priority. A starvation counter guarantees that fetch makes forward progress.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_pick.sv | 23 ++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction-fetch / load-store memory port arbiter.
// State and owner encodings are exported so checkers can bind to them.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Priority rule between fetch and data: data wins unless fetch is starved.
// Pure combinational so the rule can be unit-tested on its own.
module mem_arb_pick (
    input  logic i_if_req,
    input  logic i_d_req,
    input  logic i_starved,
    output logic o_pick_if,
    output logic o_pick_d
);

    always_comb begin
        o_pick_if = 1'b0;
        o_pick_d  = 1'b0;
        if (i_if_req && i_starved) begin
            o_pick_if = 1'b1;
        end else if (i_d_req) begin
            o_pick_d = 1'b1;
        end else if (i_if_req) begin
            o_pick_if = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and load/store, one transaction
// in flight; the response is steered back to whichever requester owns it.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_if_req,
    input  logic [ADDR_WIDTH-1:0]              i_if_addr,
    output logic                               o_if_gnt,
    output logic                               o_if_rvalid,
    output logic [DATA_WIDTH-1:0]              o_if_rdata,
    input  logic                               i_d_req,
    input  logic                               i_d_we,
    input  logic [ADDR_WIDTH-1:0]              i_d_addr,
    input  logic [DATA_WIDTH-1:0]              i_d_wdata,
    input  logic [DATA_WIDTH/8-1:0]            i_d_wstrb,
    output logic                               o_d_gnt,
    output logic                               o_d_rvalid,
    output logic [DATA_WIDTH-1:0]              o_d_rdata,
    output logic                               o_mem_req,
    output logic                               o_mem_we,
    output logic [ADDR_WIDTH-1:0]              o_mem_addr,
    output logic [DATA_WIDTH-1:0]              o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0]            o_mem_wstrb,
    input  logic                               i_mem_gnt,
    input  logic                               i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]              i_mem_rdata,
    output logic [1:0]                         o_dbg_state,
    output logic [$clog2(STARVE_LIMIT+1)-1:0]  o_dbg_starve_cnt
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    // Handshakes: a requester holds req (and its payload) until its gnt pulse,
    // which fires combinationally in the IDLE cycle the request is captured.
    // Towards memory, o_mem_req and payload are held until i_mem_gnt; exactly
    // one i_mem_rvalid follows, no earlier than the cycle after i_mem_gnt.

    arb_state_e              state_q, state_d;
    arb_owner_e              owner_q, owner_d;
    logic [CNT_W-1:0]        starve_q, starve_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH/8-1:0] mem_wstrb_q, mem_wstrb_d;

    logic pick_if;
    logic pick_d;
    logic starved;

    assign starved = (starve_q == STARVE_MAX);

    mem_arb_pick u_pick (
        .i_if_req  (i_if_req),
        .i_d_req   (i_d_req),
        .i_starved (starved),
        .o_pick_if (pick_if),
        .o_pick_d  (pick_d)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        o_if_gnt    = 1'b0;
        o_d_gnt     = 1'b0;
        o_if_rvalid = 1'b0;
        o_d_rvalid  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_if) begin
                    o_if_gnt    = 1'b1;
                    owner_d     = OWN_IF;
                    state_d     = REQ;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_if_addr;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                    starve_d    = '0;
                end else if (pick_d) begin
                    o_d_gnt     = 1'b1;
                    owner_d     = OWN_D;
                    state_d     = REQ;
                    mem_req_d   = 1'b1;
                    mem_we_d    = i_d_we;
                    mem_addr_d  = i_d_addr;
                    mem_wdata_d = i_d_wdata;
                    mem_wstrb_d = i_d_we ? i_d_wstrb : '0;
                    // Only grants made over a waiting fetch count towards starvation.
                    if (!i_if_req) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            REQ: begin
                if (i_mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                o_if_rvalid = i_mem_rvalid && (owner_q == OWN_IF);
                o_d_rvalid  = i_mem_rvalid && (owner_q == OWN_D);
                if (i_mem_rvalid) begin
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d   = IDLE;
                owner_d   = OWN_NONE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign o_if_rdata       = i_mem_rdata;
    assign o_d_rdata        = i_mem_rdata;
    assign o_mem_req        = mem_req_q;
    assign o_mem_we         = mem_we_q;
    assign o_mem_addr       = mem_addr_q;
    assign o_mem_wdata      = mem_wdata_q;
    assign o_mem_wstrb      = mem_wstrb_q;
    assign o_dbg_state      = state_q;
    assign o_dbg_starve_cnt = starve_q;

endmodule
